tap_upload_streamer: RTL

//  Core-to-HPS side of the ioctl file channel: serves hps_io upload reads (OSD "Save Tape") as a KC .TAP image built on the fly from KC85/4 memory.

---
 rtl/tap_upload_streamer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/tap_upload_streamer.sv
// Serves hps_io upload reads as a KC .TAP image (16-byte header + 129-byte blocks) built from KC memory.
// Header/block/pad bytes are ready 2 cycles after rd; data bytes 1 cycle after mem_ack; ioctl_wait stalls the HPS meanwhile.
module tap_upload_streamer #(
    parameter int ADDR_W   = 16,
    parameter int BLK_DATA = 128,
    parameter int HDR_LEN  = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              ioctl_upload,
    input  logic              ioctl_rd,
    input  logic [24:0]       ioctl_addr,
    output logic [7:0]        ioctl_din,
    output logic              ioctl_wait,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [15:0]       length,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    input  logic              mem_ack,
    output logic [24:0]       file_size,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int P_W = $clog2(BLK_DATA);
    localparam int KW  = 17 - P_W;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_HDR    = 3'd1;
    localparam logic [2:0] S_BLKNUM = 3'd2;
    localparam logic [2:0] S_FETCH  = 3'd3;
    localparam logic [2:0] S_PAD    = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]     state;
    logic           upload_q;
    logic [24:0]    exp_off;
    logic [KW-1:0]  blk_idx;
    logic [P_W-1:0] pos;
    logic [KW-1:0]  n_blk;
    logic [15:0]    length_q;
    logic           prep;

    logic [KW-1:0]  n_calc;
    logic [KW-1:0]  n_eff;
    logic [24:0]    fsize_calc;
    logic           last_blk;
    logic [7:0]     cur_byte;
    logic [2:0]     nx_state;
    logic [KW-1:0]  nx_blk;
    logic [P_W-1:0] nx_pos;
    logic           nx_payload;

    function automatic logic [7:0] hdr_byte(input logic [3:0] idx);
        case (idx)
            4'd0:    return 8'hC3;
            4'd1:    return 8'h4B;
            4'd2:    return 8'h43;
            4'd3:    return 8'h2D;
            4'd4:    return 8'h54;
            4'd5:    return 8'h41;
            4'd6:    return 8'h50;
            4'd7:    return 8'h45;
            4'd8:    return 8'h20;
            4'd9:    return 8'h62;
            4'd10:   return 8'h79;
            4'd11:   return 8'h20;
            4'd12:   return 8'h41;
            4'd13:   return 8'h46;
            4'd14:   return 8'h2E;
            default: return 8'h20;
        endcase
    endfunction

    // Zero-length saves still produce one (all-pad) block.
    assign n_calc     = KW'((17'(length) + 17'(BLK_DATA - 1)) >> P_W);
    assign n_eff      = (n_calc == '0) ? KW'(1) : n_calc;
    assign fsize_calc = 25'(HDR_LEN) + 25'(n_eff) * 25'(BLK_DATA + 1);
    assign last_blk   = (blk_idx == n_blk - KW'(1));

    always_comb begin
        cur_byte = 8'h00;
        case (state)
            S_HDR:    cur_byte = hdr_byte(exp_off[3:0]);
            S_BLKNUM: cur_byte = last_blk ? 8'hFF : 8'(blk_idx + KW'(1));
            default:  cur_byte = 8'h00;
        endcase
    end

    // Position of the byte following the current one; payload bytes split into fetch or pad by length.
    always_comb begin
        nx_state   = state;
        nx_blk     = blk_idx;
        nx_pos     = pos;
        nx_payload = 1'b0;
        case (state)
            S_HDR: begin
                if (exp_off == 25'(HDR_LEN - 1))
                    nx_state = S_BLKNUM;
            end
            S_BLKNUM: begin
                nx_pos     = '0;
                nx_payload = 1'b1;
            end
            S_FETCH, S_PAD: begin
                if (pos == P_W'(BLK_DATA - 1)) begin
                    if (last_blk) begin
                        nx_state = S_DONE;
                    end else begin
                        nx_blk   = blk_idx + KW'(1);
                        nx_pos   = '0;
                        nx_state = S_BLKNUM;
                    end
                end else begin
                    nx_pos     = pos + P_W'(1);
                    nx_payload = 1'b1;
                end
            end
            default: nx_state = state;
        endcase
        if (nx_payload)
            nx_state = ({nx_blk, nx_pos} < {1'b0, length_q}) ? S_FETCH : S_PAD;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            upload_q   <= 1'b0;
            exp_off    <= '0;
            blk_idx    <= '0;
            pos        <= '0;
            n_blk      <= '0;
            length_q   <= '0;
            prep       <= 1'b0;
            ioctl_din  <= 8'h00;
            ioctl_wait <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            file_size  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            upload_q <= ioctl_upload;
            done     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ioctl_upload && !upload_q) begin
                        state      <= S_HDR;
                        exp_off    <= '0;
                        blk_idx    <= '0;
                        pos        <= '0;
                        n_blk      <= n_eff;
                        length_q   <= length;
                        mem_addr   <= start_addr;
                        file_size  <= fsize_calc;
                        busy       <= 1'b1;
                        err        <= 1'b0;
                        ioctl_wait <= 1'b1;
                        ioctl_din  <= 8'h00;
                        prep       <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (!ioctl_upload) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    if (!ioctl_upload) begin
                        // An outstanding request is simply dropped; acks are only honoured while mem_req is high.
                        state      <= S_IDLE;
                        busy       <= 1'b0;
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        ioctl_din  <= 8'h00;
                        prep       <= 1'b0;
                    end else if (err) begin
                        state <= state;
                    end else if (ioctl_rd && (ioctl_wait || ioctl_addr != exp_off)) begin
                        err        <= 1'b1;
                        mem_req    <= 1'b0;
                        prep       <= 1'b0;
                        ioctl_wait <= 1'b0;
                        ioctl_din  <= 8'h00;
                    end else if (ioctl_rd) begin
                        exp_off <= exp_off + 25'd1;
                        state   <= nx_state;
                        blk_idx <= nx_blk;
                        pos     <= nx_pos;
                        if (state == S_FETCH || state == S_PAD)
                            mem_addr <= mem_addr + ADDR_W'(1);
                        if (nx_state == S_DONE) begin
                            done       <= 1'b1;
                            ioctl_wait <= 1'b0;
                            ioctl_din  <= 8'h00;
                        end else if (nx_state == S_FETCH) begin
                            mem_req    <= 1'b1;
                            ioctl_wait <= 1'b1;
                        end else begin
                            prep       <= 1'b1;
                            ioctl_wait <= 1'b1;
                        end
                    end else if (prep) begin
                        ioctl_din  <= cur_byte;
                        ioctl_wait <= 1'b0;
                        prep       <= 1'b0;
                    end else if (mem_req && mem_ack) begin
                        ioctl_din  <= mem_data;
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
